fir_tap_line: RTL and testbench

Parametrised tapped delay line holding the last DEPTH input samples for the FIR datapath. It generalises the single load/flush register into a DEPTH-stage shift chain with per-tap parallel outputs, a selectable tap read port, and fill tracking. It sits between the UART sample deserialiser and the FIR multiply-accumulate stage. The MAC controller uses `full` to know when a complete window is available.

---
 rtl/fir_tap_line.sv | 87 ++++++++
 tb/tb_fir_tap_line.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_line.sv
// Tapped delay line holding the last DEPTH samples for the FIR datapath.
// Each stage is a per-tap register cell. Fill tracking and a tap-select read port sit alongside the chain.

module fir_tap_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          q <= '0;
    else if (flush)    q <= '0;
    else if (shift_en) q <= d;
  end

endmodule

module fir_tap_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int SEL_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH*DEPTH-1:0] taps_out,
  input  logic [SEL_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       tap_out,
  output logic [CNT_W-1:0]       fill_count,
  output logic                   full,
  output logic                   shifted
);

  logic [WIDTH-1:0] tap [DEPTH];

  // Tap 0 takes the new sample. Every later tap takes its predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    logic [WIDTH-1:0] d;
    if (k == 0) begin : g_head
      assign d = data_in;
    end else begin : g_link
      assign d = tap[k-1];
    end

    fir_tap_cell #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .shift_en (shift_en),
      .d        (d),
      .q        (tap[k])
    );

    assign taps_out[k*WIDTH +: WIDTH] = tap[k];
  end

  // Any tap_sel value that matches no tap reads as 0. This covers DEPTH values that are not a power of two.
  always_comb begin
    tap_out = '0;
    for (int k = 0; k < DEPTH; k++)
      if (tap_sel == SEL_W'(k)) tap_out = tap[k];
  end

  assign full = (fill_count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count <= '0;
      shifted    <= 1'b0;
    end else if (flush) begin
      fill_count <= '0;
      shifted    <= 1'b0;
    end else begin
      shifted <= shift_en;
      if (shift_en && !full) fill_count <= fill_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fir_tap_line.sv
// Randomised scoreboard bench for fir_tap_line. It uses a queue-based window model and a second instance with DEPTH=5.

module tb_fir_tap_line;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int D5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, shift_en, flush;
  logic [W-1:0]   data_in, tap_out;
  logic [W*D-1:0] taps_out;
  logic [2:0]     tap_sel;
  logic [3:0]     fill_count;
  logic           full, shifted;

  logic            shift_en_b, flush_b;
  logic [W-1:0]    data_in_b, tap_out_b;
  logic [W*D5-1:0] taps_out_b;
  logic [2:0]      tap_sel_b, fill_count_b;
  logic            full_b, shifted_b;

  fir_tap_line #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .flush(flush), .data_in(data_in),
    .taps_out(taps_out), .tap_sel(tap_sel), .tap_out(tap_out),
    .fill_count(fill_count), .full(full), .shifted(shifted)
  );

  fir_tap_line #(.WIDTH(W), .DEPTH(D5)) dut_b (
    .clk(clk), .rst(rst), .shift_en(shift_en_b), .flush(flush_b), .data_in(data_in_b),
    .taps_out(taps_out_b), .tap_sel(tap_sel_b), .tap_out(tap_out_b),
    .fill_count(fill_count_b), .full(full_b), .shifted(shifted_b)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W*D-1:0] taps;
    logic [3:0]     cnt;
    logic           full;
  } exp_t;

  exp_t       sbq[$];
  logic [W-1:0] mdl[$];  // newest sample first, at most D entries
  int         mfill = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    mdl.delete();
    mfill = 0;
  endfunction

  function automatic void model_shift(input logic [W-1:0] v);
    mdl.push_front(v);
    if (mdl.size() > D) void'(mdl.pop_back());
    mfill = (mfill + 1 > D) ? D : mfill + 1;
  endfunction

  function automatic logic [W-1:0] mtap(input int k);
    return (k < mdl.size()) ? mdl[k] : '0;
  endfunction

  function automatic exp_t exp_now();
    exp_t e;
    e.taps = '0;
    for (int k = 0; k < mdl.size(); k++) e.taps[k*W +: W] = mdl[k];
    e.cnt  = 4'(mfill);
    e.full = (mfill == D);
    return e;
  endfunction

  // Monitor: every shifted pulse retires one expected window.
  exp_t me;
  always @(negedge clk) begin
    if (rst && shifted) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_shift: shifted=1 with no pending expectation");
      end else begin
        me = sbq.pop_front();
        chk("sb_taps", 128'(taps_out), 128'(me.taps));
        chk("sb_fill", 128'(fill_count), 128'(me.cnt));
        chk("sb_full", 128'(full), 128'(me.full));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input logic [W-1:0] v);
    shift_en = 1'b1;
    data_in  = v;
    model_shift(v);
    sbq.push_back(exp_now());
    tick();
    shift_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vb [D5];
    rst = 1'b0; shift_en = 1'b0; flush = 1'b0; data_in = '0; tap_sel = '0;
    shift_en_b = 1'b0; flush_b = 1'b0; data_in_b = '0; tap_sel_b = '0;

    // Reset, then fill with 1..8.
    repeat (3) tick();
    chk("rst_taps", 128'(taps_out), 128'(0));
    chk("rst_fill", 128'(fill_count), 128'(0));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_shifted", 128'(shifted), 128'(0));
    rst = 1'b1;
    tick();
    chk("rel_no_shift", 128'(fill_count), 128'(0));
    for (int i = 1; i <= 8; i++) begin
      chk("fill_not_full_yet", 128'(full), 128'(0));
      do_shift(W'(i));
    end
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_tap0", 128'(taps_out[15:0]), 128'(8));
    chk("fill_tap7", 128'(taps_out[127:112]), 128'(1));
    tick();
    chk("shifted_drop", 128'(shifted), 128'(0));

    // Saturation of the fill count.
    do_shift(16'd9);
    do_shift(16'd10);
    chk("sat_tap0", 128'(taps_out[15:0]), 128'(10));
    chk("sat_tap7", 128'(taps_out[127:112]), 128'(3));
    chk("sat_fill", 128'(fill_count), 128'(8));
    chk("sat_full", 128'(full), 128'(1));

    // A flush with shift_en also high must win.
    flush = 1'b1; shift_en = 1'b1; data_in = 16'hBEEF;
    model_clear();
    tick();
    flush = 1'b0; shift_en = 1'b0;
    chk("flush_taps", 128'(taps_out), 128'(0));
    chk("flush_fill", 128'(fill_count), 128'(0));
    chk("flush_full", 128'(full), 128'(0));
    chk("flush_shifted", 128'(shifted), 128'(0));

    // Hold the contents, then sweep the read port.
    do_shift(16'h0011);
    do_shift(16'h0022);
    do_shift(16'h0033);
    repeat (5) tick();
    chk("hold_taps", 128'(taps_out), 128'(exp_now().taps));
    chk("hold_fill", 128'(fill_count), 128'(3));
    for (int k = 0; k < D; k++) begin
      tap_sel = 3'(k);
      #1;
      chk("sweep_tap_out", 128'(tap_out), 128'(k == 0 ? 16'h0033 : k == 1 ? 16'h0022 :
                                               k == 2 ? 16'h0011 : 16'h0000));
    end

    // Random traffic against the window model.
    for (int i = 0; i < 300; i++) begin
      tap_sel = 3'($urandom_range(0, 7));
      #1;
      chk("rand_tap_out", 128'(tap_out), 128'(mtap(int'(tap_sel))));
      chk("rand_fill", 128'(fill_count), 128'(mfill));
      flush    = ($urandom_range(0, 9) == 0);
      shift_en = ($urandom_range(0, 9) < 6);
      data_in  = W'($urandom);
      if (flush) model_clear();
      else if (shift_en) begin
        model_shift(data_in);
        sbq.push_back(exp_now());
      end
      tick();
    end
    flush = 1'b0; shift_en = 1'b0;
    tick();

    // Assert reset asynchronously while the line is full.
    for (int i = 0; i < D; i++) do_shift(W'($urandom));
    tick();
    chk("pre_async_full", 128'(full), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("async_taps", 128'(taps_out), 128'(0));
    chk("async_fill", 128'(fill_count), 128'(0));
    chk("async_full", 128'(full), 128'(0));
    model_clear();
    shift_en = 1'b1; data_in = 16'h0005;
    #1;
    rst = 1'b1;
    model_shift(16'h0005);
    sbq.push_back(exp_now());
    tick();
    shift_en = 1'b0;
    chk("rel_tap0", 128'(taps_out[15:0]), 128'(5));
    chk("rel_fill", 128'(fill_count), 128'(1));
    tick();

    // Instance with DEPTH=5, which is not a power of two.
    for (int i = 0; i < D5; i++) begin
      vb[i] = W'($urandom);
      shift_en_b = 1'b1; data_in_b = vb[i];
      tick();
      chk("b_fill", 128'(fill_count_b), 128'(i + 1));
      chk("b_full", 128'(full_b), 128'(i == D5 - 1));
    end
    shift_en_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tap_sel_b = 3'(k);
      #1;
      chk("b_tap_out", 128'(tap_out_b), 128'(k < D5 ? vb[D5-1-k] : 16'h0000));
    end
    shift_en_b = 1'b1; data_in_b = 16'h1234;
    tick();
    shift_en_b = 1'b0;
    chk("b_sat_fill", 128'(fill_count_b), 128'(D5));
    chk("b_sat_tap4", 128'(taps_out_b[79:64]), 128'(vb[1]));

    tick();
    chk("sb_drained", 128'(sbq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
